// File: rtl/comm_pkg.sv
// Shared definitions for the host command transmitter and the runner's UART receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package comm_pkg;

  // Top-level sequencing of the two bytes of a command word
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;

  // Clocks per bit: 19200 baud at 50 MHz; the receiver uses the same value
  localparam int BAUD_DIV_DFLT = 2604;

  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Minimum baud counter width so the default divider and nearby values fit
  localparam int BAUD_CNT_W_MIN = 12;

  function automatic int baud_cnt_w(input int div);
    return ($clog2(div) > BAUD_CNT_W_MIN) ? $clog2(div) : BAUD_CNT_W_MIN;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV clocks.
// Latency: TX drops 1 clock after trmt is sampled; tx_done pulses 1 clock after the stop bit ends.
// Backpressure: trmt is ignored while a frame is in flight; the caller waits for tx_done.
module uart_tx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int             BW        = baud_cnt_w(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [9:0]    r_shift;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit_cnt;
  logic          r_busy;
  logic          r_done;

  // Load a frame on trmt, then shift one bit out every BAUD_DIV clocks until the stop bit ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (trmt && !r_busy) begin
        r_shift   <= {1'b1, tx_data, 1'b0};
        r_baud    <= '0;
        r_bit_cnt <= '0;
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        if (r_baud == BAUD_LAST) begin
          r_baud    <= '0;
          r_shift   <= {1'b1, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == BIT_LAST) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end else begin
          r_baud <= r_baud + 1'b1;
        end
      end
    end
  end

  // Idle line is high; gating with busy makes reset force the line high immediately
  assign TX      = r_busy ? r_shift[0] : 1'b1;
  assign tx_done = r_done;

endmodule

// File: rtl/comm_master.sv
// Sends a 16-bit command as two 8N1 bytes (high byte first) and raises a sticky completion flag.
// Latency: start bit 1 clock after acceptance; cmd_cmplt at 20*BAUD_DIV+4 clocks after acceptance.
// Backpressure: snd_cmd is only accepted in IDLE; requests during a transfer are dropped.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  output logic        cmd_cmplt
);

  state_t      r_state;
  logic [15:0] r_shadow;
  logic        r_cmplt;
  logic        r_trmt;
  logic        w_tx_done;
  logic [7:0]  w_tx_data;

  // Sequence high byte then low byte; the shadow copy isolates the frames from later cmd changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_cmplt  <= 1'b0;
      r_trmt   <= 1'b0;
    end else begin
      r_trmt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (snd_cmd) begin
            r_shadow <= cmd;
            r_cmplt  <= 1'b0;
            r_trmt   <= 1'b1;
            r_state  <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (w_tx_done) begin
            r_trmt  <= 1'b1;
            r_state <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (w_tx_done) begin
            r_cmplt <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The launch pulse lands one clock after the state change, so the state selects the byte
  assign w_tx_data = (r_state == SEND_LO) ? r_shadow[7:0] : r_shadow[15:8];

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (r_trmt),
    .tx_data (w_tx_data),
    .TX      (TX),
    .tx_done (w_tx_done)
  );

  assign cmd_cmplt = r_cmplt;

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master with a short bit time.
// Latency: n/a.
// Backpressure: n/a.
module tb_comm_master;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        TX;
  logic        cmd_cmplt;

  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    rises  = 0;
  logic  prev_c = 1'b0;
  string cur    = "init";

  typedef struct {
    logic [15:0] c;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          inject;
    string       name;
  } vec_t;

  vec_t vecs[6];

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .snd_cmd   (snd_cmd),
    .cmd       (cmd),
    .TX        (TX),
    .cmd_cmplt (cmd_cmplt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_cmplt === 1'b1 && prev_c !== 1'b1) rises <= rises + 1;
    prev_c <= cmd_cmplt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h at cycle %0d", cur, nm, act, exp, cyc);
    end
  endtask

  // Called at the first sample where TX is low; ends at the last sample of the stop bit
  task automatic rx_frame(input int inject, output logic [7:0] b, output bit bad);
    logic [9:0] f;
    bad = 1'b0;
    f   = '0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < BD; j++) begin
        int k;
        k = i * BD + j;
        if (k > 0) step();
        if (inject >= 0 && k == inject) begin
          snd_cmd = 1'b1;
          cmd     = 16'hFFFF;
        end
        if (inject >= 0 && k == inject + 1) snd_cmd = 1'b0;
        if (j == 0) f[i] = TX;
        else if (TX !== f[i]) bad = 1'b1;
      end
    end
    if (f[0] !== 1'b0 || f[9] !== 1'b1) bad = 1'b1;
    b = f[8:1];
  endtask

  task automatic wait_low(input int lim, output int n);
    n = 0;
    while (TX !== 1'b0 && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic wait_cmplt(input int lim, output int n);
    n = 0;
    while (cmd_cmplt !== 1'b1 && n < lim) begin
      step();
      n++;
    end
  endtask

  // Receives the two bytes of a command already started, then checks completion timing
  task automatic rx_cmd(input logic [7:0] ehi, input logic [7:0] elo, input int inject, input int t_acc);
    logic [7:0] b;
    bit         bad;
    int         n;
    rx_frame(inject, b, bad);
    chk("hi_byte", b, ehi);
    chk("hi_bit_width", bad, 0);
    wait_low(3, n);
    chk("hi_lo_gap", (TX === 1'b0), 1);
    rx_frame(-1, b, bad);
    chk("lo_byte", b, elo);
    chk("lo_bit_width", bad, 0);
    wait_cmplt(2, n);
    chk("cmplt_rise", cmd_cmplt, 1);
    chk("cmplt_budget", ((cyc - t_acc) <= 20 * BD + 4), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int t_acc;
    int r0;
    bit ok;
    cur = v.name;
    @(negedge clk);
    cmd     = v.c;
    snd_cmd = 1'b1;
    r0      = rises;
    step();
    t_acc   = cyc;
    snd_cmd = 1'b0;
    chk("accept_cmplt_clr", cmd_cmplt, 0);
    chk("accept_tx_idle", TX, 1);
    step();
    chk("start_latency", TX, 0);
    rx_cmd(v.hi, v.lo, v.inject, t_acc);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (TX !== 1'b1 || cmd_cmplt !== 1'b1) ok = 1'b0;
    end
    chk("idle_after_cmplt", ok, 1);
    chk("cmplt_rise_count", rises - r0, 1);
  endtask

  initial begin
    bit ok;
    int t_acc;
    int r0;

    vecs[0] = '{16'hAAAA, 8'hAA, 8'hAA, -1, "aaaa"};
    vecs[1] = '{16'h0003, 8'h00, 8'h03, -1, "0003"};
    vecs[2] = '{16'h0000, 8'h00, 8'h00, -1, "0000"};
    vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF, -1, "ffff"};
    vecs[4] = '{16'h8001, 8'h80, 8'h01, -1, "8001"};
    vecs[5] = '{16'h1234, 8'h12, 8'h34, 40, "1234_ignore"};

    // Reset held for 5 clocks, then idle line with no request
    rst_n   = 1'b0;
    snd_cmd = 1'b0;
    cmd     = 16'h0000;
    cur     = "reset";
    ok      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (TX !== 1'b1 || cmd_cmplt !== 1'b0) ok = 1'b0;
    end
    chk("in_reset", ok, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ok    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (TX !== 1'b1 || cmd_cmplt !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_reset", ok, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in data bit 4 of the high byte (0xC3 has a 0 there)
    cur = "mid_reset";
    @(negedge clk);
    cmd     = 16'hC3C3;
    snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0;
    step();
    chk("start", TX, 0);
    for (int i = 0; i < 5 * BD + 8; i++) step();
    chk("pre_reset_bit4", TX, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_tx", TX, 1);
    chk("reset_cmplt", cmd_cmplt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (TX !== 1'b1 || cmd_cmplt !== 1'b0) ok = 1'b0;
    end
    chk("post_reset_idle", ok, 1);
    run_vec('{16'h5A5A, 8'h5A, 8'h5A, -1, "5a5a_after_reset"});

    // snd_cmd held high: second command accepted right after completion
    cur = "hold";
    @(negedge clk);
    cmd     = 16'h0102;
    snd_cmd = 1'b1;
    r0      = rises;
    step();
    t_acc = cyc;
    step();
    chk("start1", TX, 0);
    rx_cmd(8'h01, 8'h02, -1, t_acc);
    step();
    t_acc = cyc;
    chk("reaccept_cmplt_clr", cmd_cmplt, 0);
    chk("reaccept_tx_idle", TX, 1);
    snd_cmd = 1'b0;
    step();
    chk("start2", TX, 0);
    rx_cmd(8'h01, 8'h02, -1, t_acc);
    step();
    step();
    chk("hold_rise_count", rises - r0, 2);
    chk("hold_final_cmplt", cmd_cmplt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
